// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings for the serial sequence generator and detectors.
package seq_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      SHIFT = 3'b001,
      GAP   = 3'b010,
      DONE  = 3'b011
   } seqState_t;
   localparam logic SEQ_IDLE = 1'b1;
endpackage

// File: rtl/sequence_gen_if.sv
// sequence_gen_if: control/serial bundle between register block, generator and consumer.
interface sequence_gen_if #(parameter int PAT_W = 8, parameter int CNT_W = 4);
   localparam int LEN_W = $clog2(PAT_W + 1);
   logic             startH;
   logic [PAT_W-1:0] patIn;
   logic [LEN_W-1:0] lenIn;
   logic [CNT_W-1:0] repIn;
   logic [CNT_W-1:0] gapIn;
   logic             sigA;
   logic             busyAH;
   logic             doneAH;
   modport master (output startH, patIn, lenIn, repIn, gapIn, input sigA, busyAH, doneAH);
   modport slave  (input startH, patIn, lenIn, repIn, gapIn, output sigA, busyAH, doneAH);
endinterface

// File: rtl/sequence_gen.sv
// sequence_gen: MSB-first serial pattern transmitter with repeat count and idle gaps.
module sequence_gen
   import seq_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 4
) (
   input logic           sysClk,
   input logic           resetL,
   sequence_gen_if.slave bus
);
   localparam int LEN_W = $clog2(PAT_W + 1);
   localparam int IDX_W = PAT_W > 1 ? $clog2(PAT_W) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
   seqState_t        state, stateNext;
   logic [PAT_W-1:0] patLat;
   logic [LEN_W-1:0] lenLat, lenClamp;
   logic [CNT_W-1:0] gapLat, repCnt, gapCnt;
   logic [IDX_W-1:0] bitCnt, bitFirst, bitFirstIn;
   logic             lastBit;
   assign lenClamp   = bus.lenIn > MAX_LEN ? MAX_LEN : bus.lenIn;
   assign bitFirst   = IDX_W'(lenLat - 1'b1);
   assign bitFirstIn = IDX_W'(lenClamp - 1'b1);
   assign lastBit    = bitCnt == '0;
   always_ff @(posedge sysClk or negedge resetL)
      if (!resetL) state <= IDLE;
      else         state <= stateNext;
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.startH) stateNext = lenClamp == '0 ? DONE : SHIFT;
         SHIFT:   if (lastBit) stateNext = repCnt == '0 ? DONE : gapLat != '0 ? GAP : SHIFT;
         GAP:     if (gapCnt == '0) stateNext = SHIFT;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end
   // Outputs are registered from the current state, so they trail it by one cycle.
   always_ff @(posedge sysClk or negedge resetL) begin
      if (!resetL) begin
         patLat     <= '0;
         lenLat     <= '0;
         gapLat     <= '0;
         repCnt     <= '0;
         gapCnt     <= '0;
         bitCnt     <= '0;
         bus.sigA   <= SEQ_IDLE;
         bus.busyAH <= 1'b0;
         bus.doneAH <= 1'b0;
      end else begin
         bus.sigA   <= state == SHIFT ? patLat[bitCnt] : SEQ_IDLE;
         bus.busyAH <= state == SHIFT || state == GAP;
         bus.doneAH <= state == DONE;
         case (state)
            IDLE: if (bus.startH) begin
               patLat <= bus.patIn;
               lenLat <= lenClamp;
               gapLat <= bus.gapIn;
               repCnt <= bus.repIn;
               bitCnt <= bitFirstIn;
            end
            SHIFT: if (!lastBit) bitCnt <= bitCnt - 1'b1;
            else if (repCnt != '0) begin
               repCnt <= repCnt - 1'b1;
               gapCnt <= gapLat - 1'b1;
               bitCnt <= bitFirst;
            end
            GAP: if (gapCnt == '0) bitCnt <= bitFirst;
            else gapCnt <= gapCnt - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sequence_gen.sv
// tb_sequence_gen: directed self-checking bench for sequence_gen.
module tb_sequence_gen;
   logic sysClk = 1'b0;
   logic resetL = 1'b0;
   int   checks = 0;
   int   errors = 0;
   sequence_gen_if #(.PAT_W(8), .CNT_W(4)) bus ();
   sequence_gen #(.PAT_W(8), .CNT_W(4)) dut (.sysClk(sysClk), .resetL(resetL), .bus(bus.slave));
   always #5 sysClk = ~sysClk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge sysClk);
      @(negedge sysClk);
   endtask

   task automatic checkIdle(input string tag);
      checkVal({tag, " sigA"}, bus.sigA, 1'b1);
      checkVal({tag, " busy"}, bus.busyAH, 1'b0);
      checkVal({tag, " done"}, bus.doneAH, 1'b0);
   endtask

   // expStream holds the expected sigA sequence MSB-first, nBits long (also the busy length).
   task automatic sendXfer(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rep, input logic [3:0] gap, input int nBits,
                           input logic [31:0] expStream, input bit disturb);
      bus.patIn  = pat;
      bus.lenIn  = len;
      bus.repIn  = rep;
      bus.gapIn  = gap;
      bus.startH = 1'b1;
      cycle();
      bus.startH = 1'b0;
      for (int i = 1; i <= nBits; i++) begin
         cycle();
         checkVal($sformatf("%s bit%0d", tag, i), bus.sigA, expStream[nBits-i]);
         checkVal($sformatf("%s busy%0d", tag, i), bus.busyAH, 1'b1);
         checkVal($sformatf("%s nodone%0d", tag, i), bus.doneAH, 1'b0);
         if (disturb && i == 3) begin
            bus.startH = 1'b1;
            bus.patIn  = 8'hFF;
            bus.lenIn  = 4'd3;
            bus.repIn  = 4'd5;
            bus.gapIn  = 4'd2;
         end
         if (disturb && i == 4) bus.startH = 1'b0;
      end
      cycle();
      checkVal({tag, " done"}, bus.doneAH, 1'b1);
      checkVal({tag, " doneBusy"}, bus.busyAH, 1'b0);
      checkVal({tag, " doneSig"}, bus.sigA, 1'b1);
      cycle();
      checkIdle({tag, " after"});
   endtask

   initial begin
      bus.startH = 1'b0;
      bus.patIn  = '0;
      bus.lenIn  = '0;
      bus.repIn  = '0;
      bus.gapIn  = '0;
      for (int i = 0; i < 4; i++) begin
         bus.startH = 1'b1;
         bus.patIn  = 8'($urandom);
         bus.lenIn  = 4'($urandom_range(1, 8));
         bus.repIn  = 4'($urandom);
         bus.gapIn  = 4'($urandom);
         cycle();
         checkIdle($sformatf("reset%0d", i));
      end
      bus.startH = 1'b0;
      resetL = 1'b1;
      cycle();
      checkIdle("postReset");
      sendXfer("single", 8'h0C, 4'd6, 4'd0, 4'd0, 6, 32'b001100, 1'b0);
      sendXfer("repGap", 8'h0C, 4'd6, 4'd2, 4'd3, 24, 32'b001100111001100111001100, 1'b0);
      sendXfer("b2b", 8'h0C, 4'd6, 4'd1, 4'd0, 12, 32'b001100001100, 1'b1);
      sendXfer("len0", 8'hFF, 4'd0, 4'd3, 4'd3, 0, 32'b0, 1'b0);
      sendXfer("clamp", 8'hA5, 4'd12, 4'd0, 4'd0, 8, 32'b10100101, 1'b0);
      // Start held through DONE must not launch a second transfer.
      bus.patIn  = 8'hFF;
      bus.lenIn  = 4'd0;
      bus.repIn  = 4'd0;
      bus.gapIn  = 4'd0;
      bus.startH = 1'b1;
      cycle();
      bus.lenIn = 4'd6;
      cycle();
      bus.startH = 1'b0;
      checkVal("doneIgn done", bus.doneAH, 1'b1);
      cycle();
      checkIdle("doneIgn idle");
      cycle();
      checkIdle("doneIgn idle2");
      // Asynchronous reset during the third bit of 110011.
      bus.patIn  = 8'h33;
      bus.lenIn  = 4'd6;
      bus.startH = 1'b1;
      cycle();
      bus.startH = 1'b0;
      cycle();
      checkVal("midRst bit1", bus.sigA, 1'b1);
      cycle();
      checkVal("midRst bit2", bus.sigA, 1'b1);
      cycle();
      checkVal("midRst bit3", bus.sigA, 1'b0);
      checkVal("midRst busy3", bus.busyAH, 1'b1);
      #1 resetL = 1'b0;
      #1 checkIdle("midRst async");
      cycle();
      checkIdle("midRst held");
      resetL = 1'b1;
      cycle();
      checkIdle("midRst released");
      sendXfer("restart", 8'h0C, 4'd6, 4'd0, 4'd0, 6, 32'b001100, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
